// File: rtl/spi_host_pkg.sv
// Shared definitions for the host-side SPI initiator: FSM state encoding,
// default packet geometry, and a counter-width helper.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } spi_state_e;

    // Packet width agreed with the chip-side SPI minion.
    localparam int SPI_NBITS   = 20;
    localparam int SPI_CLK_DIV = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_host_halfcnt.sv
// Half-period timer: down-counter reloaded with CLK_DIV-1, emitting a
// one-cycle tick when it reaches zero.
module spi_host_halfcnt
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Holding load keeps the counter parked at RELOAD, so the first
    // half-period after a load is exactly CLK_DIV cycles long.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load || (cnt_reg == '0)) begin
            cnt_reg <= RELOAD;
        end else begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign tick = !load && (cnt_reg == '0);

endmodule

// File: rtl/spi_host_initiator.sv
// Host-side SPI mode-0 initiator: one send word becomes one full-duplex
// transaction; the word captured from miso is returned on the recv stream.
module spi_host_initiator
    import spi_host_pkg::*;
#(
    parameter int NBITS   = SPI_NBITS,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_val,
    output logic             send_rdy,
    input  logic [NBITS-1:0] send_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic [NBITS-1:0] recv_msg,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(NBITS + 1);

    spi_state_e       state_reg, state_next;
    logic [NBITS-1:0] tx_reg, tx_next;
    logic [NBITS-1:0] rx_reg, rx_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [NBITS-1:0] recv_msg_reg, recv_msg_next;
    logic             recv_val_reg, recv_val_next;
    logic             cs_reg, cs_next;
    logic             sclk_reg, sclk_next;
    logic             mosi_reg, mosi_next;
    logic             half_tick;

    spi_host_halfcnt #(
        .CLK_DIV (CLK_DIV)
    ) u_halfcnt (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == IDLE),
        .tick  (half_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            tx_reg       <= '0;
            rx_reg       <= '0;
            bit_cnt_reg  <= '0;
            recv_msg_reg <= '0;
            recv_val_reg <= 1'b0;
            cs_reg       <= 1'b1;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            bit_cnt_reg  <= bit_cnt_next;
            recv_msg_reg <= recv_msg_next;
            recv_val_reg <= recv_val_next;
            cs_reg       <= cs_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        bit_cnt_next  = bit_cnt_reg;
        recv_msg_next = recv_msg_reg;
        recv_val_next = recv_val_reg;
        cs_next       = cs_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;

        if (recv_val_reg && recv_rdy) begin
            recv_val_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (send_val && send_rdy) begin
                    state_next   = SETUP;
                    cs_next      = 1'b0;
                    sclk_next    = 1'b0;
                    mosi_next    = send_msg[NBITS-1];
                    tx_next      = send_msg;
                    bit_cnt_next = '0;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    state_next = HIGH;
                    sclk_next  = 1'b1;
                    rx_next    = {rx_reg[NBITS-2:0], miso};
                end
            end
            HIGH: begin
                // mosi only moves on the falling sclk edge.
                if (half_tick) begin
                    state_next   = LOW;
                    sclk_next    = 1'b0;
                    tx_next      = tx_reg << 1;
                    mosi_next    = tx_reg[NBITS-2];
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                end
            end
            LOW: begin
                if (half_tick) begin
                    if (bit_cnt_reg == BW'(NBITS)) begin
                        state_next    = GAP;
                        cs_next       = 1'b1;
                        mosi_next     = 1'b0;
                        recv_msg_next = rx_reg;
                        recv_val_next = 1'b1;
                    end else begin
                        state_next = HIGH;
                        sclk_next  = 1'b1;
                        rx_next    = {rx_reg[NBITS-2:0], miso};
                    end
                end
            end
            GAP: begin
                if (half_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign send_rdy = (state_reg == IDLE) && !recv_val_reg;
    assign recv_val = recv_val_reg;
    assign recv_msg = recv_msg_reg;
    assign cs       = cs_reg;
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;

endmodule

// File: tb/tb_spi_host_initiator.sv
// Directed bench for spi_host_initiator: a 20-bit/div-2 instance with a
// loopback or minion-model miso, plus a 2-bit/div-1 loopback instance.
module tb_spi_host_initiator;

    localparam int N = 20;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;

    logic         send_val = 1'b0;
    logic         send_rdy;
    logic [N-1:0] send_msg = '0;
    logic         recv_val;
    logic         recv_rdy = 1'b0;
    logic [N-1:0] recv_msg;
    logic         cs, sclk, mosi, miso;

    logic         s_send_val = 1'b0;
    logic         s_send_rdy;
    logic [1:0]   s_send_msg = '0;
    logic         s_recv_val;
    logic [1:0]   s_recv_msg;
    logic         s_cs, s_sclk, s_mosi;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_host_initiator #(.NBITS(N), .CLK_DIV(H)) dut (
        .clk(clk), .reset(reset),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_host_initiator #(.NBITS(2), .CLK_DIV(1)) dut_s (
        .clk(clk), .reset(reset),
        .send_val(s_send_val), .send_rdy(s_send_rdy), .send_msg(s_send_msg),
        .recv_val(s_recv_val), .recv_rdy(1'b0), .recv_msg(s_recv_msg),
        .cs(s_cs), .sclk(s_sclk), .mosi(s_mosi), .miso(s_mosi)
    );

    // Minion model: shifts resp out MSB first, captures mosi on sclk rise.
    logic         loop_mode = 1'b1;
    logic [N-1:0] resp = '0;
    logic [N-1:0] cap = '0;
    logic         model_bit;
    int           k = 0;

    always @(negedge cs) begin
        k = 0;
        cap = '0;
    end
    always @(posedge sclk) begin
        cap = {cap[N-2:0], mosi};
        k++;
    end
    always_comb begin
        model_bit = 1'b0;
        if (k < N) model_bit = resp[5'(N - 1 - k)];
    end
    assign miso = loop_mode ? mosi : model_bit;

    // Line monitor sampled mid-cycle.
    int   cs_low_cnt = 0, rise_cnt = 0, fall_cnt = 0, viol = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
    always @(negedge clk) begin
        if (!cs) cs_low_cnt++;
        if (sclk && !prev_sclk) rise_cnt++;
        if (sclk && (mosi != prev_mosi)) viol++;
        if (!cs && prev_cs) fall_cnt++;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_cs   = cs;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Counts edges from now until recv_val is seen.
    task automatic wait_recv(output int lat);
        lat = 0;
        for (int i = 0; i < 400 && !recv_val; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic send_word(input logic [N-1:0] msg, output int lat);
        @(negedge clk);
        check("send_rdy_before_accept", send_rdy, 1);
        cs_low_cnt = 0;
        rise_cnt   = 0;
        send_val   = 1'b1;
        send_msg   = msg;
        @(posedge clk);
        #1;
        send_val = 1'b0;
        send_msg = ~msg;
        wait_recv(lat);
    endtask

    task automatic consume();
        @(negedge clk);
        recv_rdy = 1'b1;
        @(negedge clk);
        recv_rdy = 1'b0;
        check("recv_val_cleared", recv_val, 0);
    endtask

    initial begin
        int lat, g, n, rdy_seen, fall_base;
        logic [4:0] sclk_seq;
        logic       cs_acc, psc;

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_recv_val", recv_val, 0);
        check("rst_recv_msg", recv_msg, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("send_rdy_after_reset", send_rdy, 1);

        // Loopback 0xA5A5A
        loop_mode = 1'b1;
        send_word(20'hA5A5A, lat);
        check("loop_latency", lat, 82);
        check("loop_cs_low", cs_low_cnt, 82);
        check("loop_sclk_rises", rise_cnt, 20);
        check("loop_recv_msg", recv_msg, 20'hA5A5A);
        consume();

        // Minion model: send 0x12345, minion answers 0x0F0F0
        loop_mode = 1'b0;
        resp = 20'h0F0F0;
        send_word(20'h12345, lat);
        check("model_latency", lat, 82);
        check("model_recv_msg", recv_msg, 20'h0F0F0);
        check("model_captured", cap, 20'h12345);
        check("model_mosi_stable", viol, 0);

        // Unconsumed word blocks new sends
        @(negedge clk);
        send_val  = 1'b1;
        send_msg  = 20'h11111;
        fall_base = fall_cnt;
        rdy_seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (send_rdy) rdy_seen++;
        end
        check("blocked_send_rdy", rdy_seen, 0);
        check("blocked_cs_falls", fall_cnt - fall_base, 0);
        check("blocked_recv_msg_kept", recv_msg, 20'h0F0F0);
        loop_mode = 1'b1;
        recv_rdy  = 1'b1;
        @(negedge clk);
        recv_rdy = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && cs; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("second_accept_cs", cs, 0);
        send_msg = 20'h3C3C3;
        recv_rdy = 1'b1;
        wait_recv(lat);
        check("second_latency", lat, 82);
        check("second_recv_msg", recv_msg, 20'h11111);

        // recv_rdy high as recv_val rises; send_val still held:
        // GAP (HALF cycles) plus one IDLE cycle before the next accept.
        g = 0;
        for (int i = 0; i < 20 && (g == 0 || cs); i++) begin
            @(posedge clk);
            #1;
            g++;
            if (g == 1) check("same_cycle_consume", recv_val, 0);
        end
        check("cs_high_gap", g, H + 1);
        send_val = 1'b0;
        wait_recv(lat);
        recv_rdy = 1'b0;
        check("third_latency", lat, 82);
        check("third_recv_msg", recv_msg, 20'h3C3C3);
        consume();

        // Small instance: NBITS=2, CLK_DIV=1, loopback 2'b10
        @(negedge clk);
        check("small_send_rdy", s_send_rdy, 1);
        s_send_val = 1'b1;
        s_send_msg = 2'b10;
        @(posedge clk);
        #1;
        s_send_val = 1'b0;
        s_send_msg = 2'b01;
        sclk_seq = '0;
        cs_acc   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            sclk_seq = {sclk_seq[3:0], s_sclk};
            cs_acc   = cs_acc | s_cs;
        end
        check("small_sclk_seq", sclk_seq, 5'b01010);
        check("small_cs_low5", cs_acc, 0);
        @(negedge clk);
        check("small_cs_high", s_cs, 1);
        check("small_recv_val", s_recv_val, 1);
        check("small_recv_msg", s_recv_msg, 2'b10);

        // Reset on the 7th sclk rising edge
        @(negedge clk);
        send_val = 1'b1;
        send_msg = 20'h5A5A5;
        @(posedge clk);
        #1;
        send_val = 1'b0;
        n   = 0;
        psc = sclk;
        for (int i = 0; i < 200 && n < 7; i++) begin
            @(posedge clk);
            #1;
            if (sclk && !psc) n++;
            psc = sclk;
        end
        check("rst_mid_edge_count", n, 7);
        reset = 1'b1;
        #1;
        check("rst_mid_cs", cs, 1);
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_mosi", mosi, 0);
        check("rst_mid_recv_val", recv_val, 0);
        @(negedge clk);
        reset = 1'b0;
        send_word(20'h0ACE1, lat);
        check("post_rst_latency", lat, 82);
        check("post_rst_cs_low", cs_low_cnt, 82);
        check("post_rst_sclk_rises", rise_cnt, 20);
        check("post_rst_recv_msg", recv_msg, 20'h0ACE1);
        consume();
        check("mosi_stable_overall", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
